// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin sharing of one fixed-latency adder with credit-guarded result FIFO
// Optional per-requester grant and stall counters are enabled by ADD_ARB_PERF_CNT_EN.
module adder_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADD_LAT    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_sum,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_sum,
  input  logic                  resp_ready
`ifdef ADD_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]      op_a [NUM_REQ];
  logic [31:0]      op_b [NUM_REQ];
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  scan_id;
  logic             grant_found;
  logic             issue_ok;
  logic             issue;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_occ;
  logic [31:0]      add_a_q;
  logic [31:0]      add_b_q;
  logic             tag_v  [ADD_LAT];
  logic [ID_W-1:0]  tag_id [ADD_LAT];
  logic             push;
  logic             pop;
  logic [ID_W+31:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g] = req_a[32*g +: 32];
    assign op_b[g] = req_b[32*g +: 32];
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every in-flight op already owns a FIFO slot, so the adder never needs to stall.
  assign issue_ok = (int'(inflight) + int'(fifo_occ)) < FIFO_DEPTH;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_found && req_valid[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  assign issue = !rst && issue_ok && grant_found;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  assign add_a = rst ? '0 : (issue ? op_a[grant_id] : add_a_q);
  assign add_b = rst ? '0 : (issue ? op_b[grant_id] : add_b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      inflight <= '0;
    end else begin
      if (issue) begin
        rr_ptr  <= ID_W'((int'(grant_id) + 1) % NUM_REQ);
        add_a_q <= op_a[grant_id];
        add_b_q <= op_b[grant_id];
      end
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // The last tag stage lines up with add_sum of the same operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= issue;
      tag_id[0] <= grant_id;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign push       = tag_v[ADD_LAT-1];
  assign resp_valid = (fifo_occ != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_id    = fifo_mem[rd_ptr][ID_W+31:32];
  assign resp_sum   = fifo_mem[rd_ptr][31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_occ <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {tag_id[ADD_LAT-1], add_sum};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_occ <= fifo_occ + 1'b1;
        2'b01:   fifo_occ <= fifo_occ - 1'b1;
        default: fifo_occ <= fifo_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_occ == CNT_W'(FIFO_DEPTH)));
  end

`ifdef ADD_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && grant_id == ID_W'(i) && grant_cnt[16*i +: 16] != 16'hFFFF)
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
      if (|req_valid && !issue_ok && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter with a behavioural adder
module tb_adder_share_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int ADD_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic [31:0]           add_sum;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_sum;
  logic                  resp_ready;
`ifdef ADD_ARB_PERF_CNT_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  adder_share_arbiter #(
    .NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum), .resp_ready(resp_ready)
`ifdef ADD_ARB_PERF_CNT_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural adder: operands captured on the issue edge, sum valid ADD_LAT cycles after issue.
  logic [31:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= add_a + add_b;
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_sum = add_pipe[ADD_LAT-1];

  int               n_cmp = 0;
  int               n_err = 0;
  logic [31:0]      a_drv [NUM_REQ];
  logic [31:0]      b_drv [NUM_REQ];
  int               pend  [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_last = '0;
  logic [ID_W+31:0] exp_q [$];
  int               gnt_log [$];
  int               resp_log [$];
  bit               rand_ready = 1'b0;
  int               base;
  int               rbase;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = (pend[i] > 0);
      req_a[32*i +: 32]   = a_drv[i];
      req_b[32*i +: 32]   = b_drv[i];
    end
  endtask

  // One clock: granted requesters consume a pending op and present fresh operands.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_last[i]) begin
        if (pend[i] > 0) pend[i]--;
        a_drv[i] = $urandom;
        b_drv[i] = $urandom;
      end
    end
    if (rand_ready) resp_ready = ($urandom_range(0, 3) != 0);
    drive();
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input int n);
    a_drv[i] = a;
    b_drv[i] = b;
    pend[i]  = n;
    drive();
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    clear_pend();
    exp_q.delete();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int max, input string tag);
    int b0;
    int k;
    b0 = gnt_log.size();
    k  = 0;
    while (gnt_log.size() < b0 + n && k < max) begin
      step();
      k++;
    end
    check_eq(tag, gnt_log.size() - b0, n);
  endtask

  task automatic drain(input int max, input string tag);
    int k;
    k = 0;
    clear_pend();
    rand_ready = 1'b0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && k < max) begin
      step();
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      gnt_last = '0;
    end else begin
      gnt_last = req_ready;
      if (req_ready != '0) begin
        int id;
        id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) id = i;
        check_eq("grant_onehot", $onehot(req_ready), 1);
        exp_q.push_back({ID_W'(id), a_drv[id] + b_drv[id]});
        gnt_log.push_back(id);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("resp_unexpected", exp_q.size(), 1);
        end else begin
          logic [ID_W+31:0] e;
          e = exp_q.pop_front();
          check_eq("resp_id", resp_id, e[ID_W+31:32]);
          check_eq("resp_sum", resp_sum, e[31:0]);
          resp_log.push_back(int'(resp_id));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
      pend[i]  = 1;
    end
    drive();
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_id", resp_id, 0);
    check_eq("rst_resp_sum", resp_sum, 0);
    check_eq("rst_add_a", add_a, 0);
    check_eq("rst_add_b", add_b, 0);
    clear_pend();
    step();
    rst = 1'b0;

    // Single request from requester 2
    resp_ready = 1'b1;
    step();
    set_op(2, 32'h0000_0005, 32'h0000_0007, 1);
    @(negedge clk);
    check_eq("single_grant", req_ready, 4'b0100);
    check_eq("single_add_a", add_a, 32'h5);
    check_eq("single_add_b", add_b, 32'h7);
    repeat (3) step();
    @(negedge clk);
    check_eq("single_push_cycle_valid", resp_valid, 0);
    step();
    @(negedge clk);
    check_eq("single_resp_valid", resp_valid, 1);
    check_eq("single_resp_id", resp_id, 2);
    check_eq("single_resp_sum", resp_sum, 32'h0000_000C);
    drain(20, "single_drain");

    // Round-robin fairness
    do_reset(2);
    resp_ready = 1'b1;
    base  = gnt_log.size();
    rbase = resp_log.size();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 2;
    drive();
    wait_grants(8, 80, "rr_grants");
    drain(40, "rr_drain");
    for (int k = 0; k < 8; k++) begin
      check_eq("rr_order", gnt_log[base+k], k % NUM_REQ);
      check_eq("rr_resp_order", resp_log[rbase+k], k % NUM_REQ);
    end

    // Backpressure: credits cap issues at FIFO_DEPTH
    resp_ready = 1'b0;
    base = gnt_log.size();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 3;
    drive();
    repeat (10) step();
    @(negedge clk);
    check_eq("bp_issue_count", gnt_log.size() - base, FIFO_DEPTH);
    check_eq("bp_blocked", req_ready, 0);
    check_eq("bp_full_head", resp_valid, 1);
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_no_bypass", req_ready, 0);
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_one_issue", req_ready, 4'b0001);
    repeat (5) step();
    @(negedge clk);
    check_eq("bp_total", gnt_log.size() - base, FIFO_DEPTH + 1);
    drain(60, "bp_drain");

    // Wrap and carry, then pointer wrap under random backpressure
    step();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    wait_grants(1, 10, "carry_grant0");
    set_op(0, 32'h8000_0000, 32'h8000_0000, 1);
    wait_grants(1, 10, "carry_grant1");
    drain(30, "carry_drain");
    rbase = resp_log.size();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, $urandom, $urandom, 6);
    rand_ready = 1'b1;
    wait_grants(20, 400, "wrap_grants");
    drain(200, "wrap_drain");

    // Concurrent push and pop around occupancy 2
    resp_ready = 1'b0;
    step();
    set_op(1, $urandom, $urandom, 2);
    repeat (8) step();
    @(negedge clk);
    check_eq("sim_head_valid", resp_valid, 1);
    rbase = resp_log.size();
    resp_ready = 1'b1;
    set_op(1, $urandom, $urandom, 6);
    wait_grants(6, 60, "sim_grants");
    drain(60, "sim_drain");
    check_eq("sim_resp_count", resp_log.size() - rbase, 8);

    // Reset while operations are in flight
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) pend[i] = 1;
    drive();
    wait_grants(3, 20, "mid_grants");
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("mid_no_resp", resp_valid, 0);
      step();
    end
    base = gnt_log.size();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1;
    drive();
    wait_grants(1, 5, "mid_regrant");
    check_eq("mid_rr_reset", gnt_log[base], 0);
    drain(40, "mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
